// File: rtl/grn_dsm_writer.sv
// GRN DSM status writer: turns AFU status-report requests into one 64B CCI-P c1 write
// to hc_dsm_base + line, then waits for the tagged write response and pulses done.
package ccip_if_pkg;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4, eREQ_INTR     = 4'h6
    } t_ccip_c1_req;
    typedef enum logic [3:0] {eRSP_WRLINE = 4'h1, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;
endpackage

module grn_dsm_writer
    import ccip_if_pkg::*;
#(
    parameter int          DSM_LINES   = 4,
    parameter logic [15:0] MDATA_TAG   = 16'hD5A0,
    parameter int          RSP_TIMEOUT = 4096,
    localparam int         LW          = (DSM_LINES > 1) ? $clog2(DSM_LINES) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [41:0]    hc_dsm_base,
    input  logic           enable,
    // req: a request transfers on every cycle where req_valid && req_ready; req_valid must
    // not depend on req_ready, and req_ready never depends on req_valid (state only).
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [LW-1:0]  req_line,
    input  logic [31:0]    req_status,
    output t_if_ccip_c1_Tx c1Tx,
    input  logic           c1TxAlmFull,
    input  t_if_ccip_c1_Rx c1Rx,
    output logic           done,
    output logic           err_timeout,
    output logic           err_nobase,
    output logic [1:0]     dbg_state
);
    localparam int TW = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RSP = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [63:0]        cyc, cyc_q;
    logic [31:0]        seq, status_q;
    logic [LW-1:0]      line_q;
    logic [TW-1:0]      timer;
    logic               rsp_match, timer_expired, accept, issue_fire;
    t_ccip_c1_ReqMemHdr wr_hdr;
    logic               unused_rsp_bits;

    assign req_ready     = (state == IDLE);
    assign dbg_state     = state;
    assign accept        = req_ready && req_valid;
    assign issue_fire    = (state == ISSUE) && !c1TxAlmFull;
    assign rsp_match     = c1Rx.rspValid && (c1Rx.hdr.resp_type == eRSP_WRLINE)
                           && (c1Rx.hdr.mdata == MDATA_TAG);
    assign timer_expired = (timer == TW'(RSP_TIMEOUT - 1));
    assign unused_rsp_bits = ^{c1Rx.hdr.vc_used, c1Rx.hdr.rsvd1, c1Rx.hdr.hit_miss,
                               c1Rx.hdr.format, c1Rx.hdr.rsvd0, c1Rx.hdr.cl_num};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid && (hc_dsm_base != '0)) state_nxt = ISSUE;
            ISSUE:    if (!c1TxAlmFull) state_nxt = WAIT_RSP;
            WAIT_RSP: if (rsp_match || timer_expired) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Address is base + line in the 42-bit cache-line space; carries past bit 41 are dropped.
    always_comb begin
        wr_hdr          = '0;
        wr_hdr.vc_sel   = eVC_VA;
        wr_hdr.sop      = 1'b1;
        wr_hdr.cl_len   = eCL_LEN_1;
        wr_hdr.req_type = eREQ_WRLINE_I;
        wr_hdr.address  = hc_dsm_base + t_ccip_clAddr'(line_q);
        wr_hdr.mdata    = MDATA_TAG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c1Tx        <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_nobase  <= 1'b0;
            seq         <= '0;
            cyc         <= '0;
            cyc_q       <= '0;
            status_q    <= '0;
            line_q      <= '0;
            timer       <= '0;
        end else begin
            c1Tx.valid <= 1'b0;
            done       <= 1'b0;
            cyc        <= enable ? cyc + 64'd1 : 64'd0;
            timer      <= (state == WAIT_RSP) ? timer + TW'(1) : '0;
            if (accept) begin
                line_q   <= req_line;
                status_q <= req_status;
                cyc_q    <= cyc;
                if (hc_dsm_base == '0) err_nobase <= 1'b1;
            end
            if (issue_fire) begin
                c1Tx.valid <= 1'b1;
                c1Tx.hdr   <= wr_hdr;
                c1Tx.data  <= {384'd0, cyc_q, seq, status_q};
            end
            // A response landing in the final timer cycle still counts as success.
            if (state == WAIT_RSP) begin
                if (rsp_match) begin
                    done <= 1'b1;
                    seq  <= seq + 32'd1;
                end else if (timer_expired) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end
endmodule
